keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD layout) and produces the debounced 4-bit digit code consumed by the game block's `keyboard_input`. It is the producer end of that interface. It drives one active-low column at a time, samples the active-low rows, and debounces across full sweeps. It emits a held key code, a valid flag and a one-cycle press strobe. It sits between the board keypad pins and the game logic.

## Interface
- `SCAN_DIV`, 100000: clock cycles per column slot (1 ms at 100 MHz); minimum 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical sweeps required to accept a change; minimum 1.
- `clock` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `row` in 4: keypad rows, active-low, externally pulled up; asynchronous to `clock`.
- `col` out 4: keypad columns, active-low one-hot.
- `key_code` out 4: debounced key; 4'hF when no key is held.
- `key_valid` out 1: high while a debounced key is held. It distinguishes key F from "none".
- `key_press` out 1: one-cycle strobe when a new debounced key is accepted.

## Operation
- Key map is `code[row][col]`:
  - row0 = 1,2,3,A
  - row1 = 4,5,6,B
  - row2 = 7,8,9,C
  - row3 = 0,F,E,D
- `row` passes through a 2-flop synchronizer before any use.
- FSM states:
  - COL0..COL3: drive `col` = ~(1<<c).
  - Slot counter counts 0..SCAN_DIV-1.
  - On count SCAN_DIV-1, latch synchronized rows into `hits[c]` and advance to the next column.
  - COL3 → EVAL.
- EVAL (one cycle; `col` keeps COL3 value), classify the sweep's 16 hits:
  - Zero hits → candidate NONE.
  - Exactly one hit → candidate = mapped code.
  - Two or more hits → candidate INVALID. The stability counter resets to 0, and stable state holds. Ghosting/multi-press never produces a key.
  - Then go to COL0 with the slot counter at 0.
- Debounce:
  - If candidate equals the previous sweep's candidate, increment the stability count, saturating at DEBOUNCE_SCANS.
  - Otherwise set the count to 1.
  - When the count reaches DEBOUNCE_SCANS and candidate ≠ stable, stable ← candidate.
- Outputs from stable state:
  - NONE → `key_code` = 4'hF, `key_valid` = 0.
  - Key k → `key_code` = k, `key_valid` = 1.
- `key_press` = 1 for exactly one cycle whenever stable changes to a key. This covers NONE→k and k→j (a rolled key without release). Changing to NONE gives no strobe.
- Holding a key never re-strobes; there is no auto-repeat.

## Timing
- Reset values (asynchronous, immediate):
  - `col` = 4'b1110 (COL0)
  - `key_code` = 4'hF
  - `key_valid` = 0
  - `key_press` = 0
  - Slot counter = 0; hits, candidate and stability count cleared; stable = NONE.
- Sweep period = 4·SCAN_DIV + 1 cycles.
- Row sample point is the last cycle of a slot. Settle time is SCAN_DIV-1 cycles plus the 2-cycle sync delay, which is absorbed because SCAN_DIV ≥ 4.
- All outputs are registered.
  - `key_code`, `key_valid` and `key_press` update together, in the cycle after the accepting EVAL.
- Press-to-strobe latency: at most (DEBOUNCE_SCANS+1) sweeps plus 3 cycles.
- A glitch shorter than one slot affects at most one sweep. It is rejected when DEBOUNCE_SCANS ≥ 2.
- Reset asserted mid-sweep aborts the sweep. No strobe is emitted on reset deassertion.
- The slot counter is $clog2(SCAN_DIV) bits and wraps only via the explicit compare, never via overflow.

## Structure
- Shared package `keypad_pkg`:
  - `KEY_NONE` = 4'hF
  - the 4x4 key-map constant array
  - state enum COL0..COL3, EVAL
- One natural sub-module: `keypad_debounce`. It takes candidate/valid-sweep and produces stable code, `key_valid` and `key_press`.
- The scanner FSM and synchronizer stay in the top.

## Test plan
Run with SCAN_DIV=4, DEBOUNCE_SCANS=2. The keypad model pulls row r low while col c is low and key (r,c) is held.

- Reset, no keys for 5 sweeps:
  - `col` cycles 1110→1101→1011→0111.
  - `key_code` = F, `key_valid` = 0, `key_press` never asserts.
- Hold key (row1, col2):
  - Within 3 sweeps plus 3 cycles, `key_code` = 6 and `key_valid` = 1.
  - Exactly one `key_press` strobe.
  - Holding 10 more sweeps gives no further strobe.
  - On release: `key_code` = F and `key_valid` = 0 after 2 sweeps, with no strobe.
- Hold key (row3, col1):
  - `key_code` = F, `key_valid` = 1, one strobe.
- Hold (row0, col0) and (row2, col3) simultaneously from idle:
  - `key_code` stays F, `key_valid` stays 0, no strobe.
- Hold 5 until accepted, then roll to 9 without release:
  - `key_code` goes 5→9 with a second strobe.
  - `key_valid` never drops.
- Assert `reset_n` low mid-slot while 8 is accepted:
  - Outputs reset asynchronously: `col` = 1110, `key_code` = F.
  - After release with 8 still held, re-acquire with one strobe.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 matrix keypad scanner.
// Key map is indexed [row][col] to match the physical keypad layout.
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'hF;

  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  typedef enum logic [2:0] {
    COL0 = 3'd0,
    COL1 = 3'd1,
    COL2 = 3'd2,
    COL3 = 3'd3,
    EVAL = 3'd4
  } scan_state_e;

  typedef enum logic [1:0] {
    CAND_NONE    = 2'd0,
    CAND_KEY     = 2'd1,
    CAND_INVALID = 2'd2
  } cand_kind_e;

endpackage

// File: rtl/keypad_debounce.sv
// Sweep-level debouncer: accepts a candidate after DEBOUNCE_SCANS identical sweeps
// and produces the held key code, valid flag and one-cycle press strobe.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sweep_done_i,
  input  cand_kind_e cand_kind_i,
  input  logic [3:0] cand_code_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_press_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  cand_kind_e    prev_kind_q, prev_kind_d;
  logic [3:0]    prev_code_q, prev_code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          press_q, press_d;
  logic          same_as_prev;
  logic          differs_from_stable;

  // Key F and "none" share a code, so the kind must take part in every compare.
  assign same_as_prev = (prev_kind_q == cand_kind_i) &&
                        ((cand_kind_i != CAND_KEY) || (prev_code_q == cand_code_i));
  assign differs_from_stable = (cand_kind_i == CAND_KEY) ?
                               (!valid_q || (code_q != cand_code_i)) : valid_q;

  always_comb begin
    prev_kind_d = prev_kind_q;
    prev_code_d = prev_code_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    valid_d     = valid_q;
    press_d     = 1'b0;
    if (sweep_done_i) begin
      prev_kind_d = cand_kind_i;
      prev_code_d = cand_code_i;
      if (cand_kind_i == CAND_INVALID) begin
        cnt_d = '0;
      end else begin
        if (same_as_prev) begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
        end else begin
          cnt_d = CW'(1);
        end
        if ((cnt_d == CNT_MAX) && differs_from_stable) begin
          valid_d = (cand_kind_i == CAND_KEY);
          code_d  = (cand_kind_i == CAND_KEY) ? cand_code_i : KEY_NONE;
          press_d = (cand_kind_i == CAND_KEY);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_kind_q <= CAND_NONE;
      prev_code_q <= KEY_NONE;
      cnt_q       <= '0;
      code_q      <= KEY_NONE;
      valid_q     <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      press_q     <= press_d;
    end
  end

  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_press_o = press_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: drives one active-low column per slot, samples the
// synchronized rows at the end of each slot and classifies the sweep in EVAL.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  logic [3:0]      row_s1_q, row_s2_q;
  scan_state_e     state_q, state_d;
  logic [CW-1:0]   slot_q, slot_d;
  logic [3:0][3:0] hits_q, hits_d;   // [col][row], 1 = switch closed
  logic [3:0]      col_q, col_d;
  logic [1:0]      n_hits;           // saturates at 2: only 0 / 1 / many matters
  logic [3:0]      hit_code;
  cand_kind_e      cand_kind;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    hits_d  = hits_q;
    if (state_q == EVAL) begin
      state_d = COL0;
      slot_d  = '0;
    end else if (slot_q == SLOT_LAST) begin
      hits_d[state_q[1:0]] = ~row_s2_q;
      slot_d = '0;
      case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL3;
        default: state_d = EVAL;
      endcase
    end else begin
      slot_d = slot_q + CW'(1);
    end
  end

  // EVAL keeps the COL3 drive so the lines do not glitch for one cycle.
  always_comb begin
    case (state_d)
      COL0:    col_d = 4'b1110;
      COL1:    col_d = 4'b1101;
      COL2:    col_d = 4'b1011;
      default: col_d = 4'b0111;
    endcase
  end

  always_comb begin
    n_hits   = 2'd0;
    hit_code = KEY_NONE;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (hits_q[c][r]) begin
          if (n_hits != 2'd2) n_hits = n_hits + 2'd1;
          hit_code = KEY_MAP[r][c];
        end
      end
    end
    if (n_hits == 2'd0)      cand_kind = CAND_NONE;
    else if (n_hits == 2'd1) cand_kind = CAND_KEY;
    else                     cand_kind = CAND_INVALID;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      state_q  <= COL0;
      slot_q   <= '0;
      hits_q   <= '0;
      col_q    <= 4'b1110;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      state_q  <= state_d;
      slot_q   <= slot_d;
      hits_q   <= hits_d;
      col_q    <= col_d;
    end
  end

  assign col = col_q;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clock        (clock),
    .reset_n      (reset_n),
    .sweep_done_i (state_q == EVAL),
    .cand_kind_i  (cand_kind),
    .cand_code_i  (hit_code),
    .key_code_o   (key_code),
    .key_valid_o  (key_valid),
    .key_press_o  (key_press)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows, a sweep-level
// behavioural model predicts the outputs and is compared on every falling edge.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DS    = 2;
  localparam int SWEEP = 4 * SD + 1;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_press;

  bit held [4][4];
  bit snap [4][4];
  int kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  int checks    = 0;
  int errors    = 0;
  int press_cnt = 0;
  int e_m       = 0;
  int q_m       = 0;
  int stable_m  = -1;
  int hist [$];

  logic [3:0] exp_col;
  logic [3:0] exp_code;
  logic       exp_valid;
  logic       exp_press;

  always #5 clock = ~clock;

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_SCANS (DS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_press (key_press)
  );

  // Physical keypad: a held key shorts its row to its column when that column is low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r][c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_m = 0;
    q_m = 0;
    stable_m = -1;
    hist.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) snap[r][c] = 1'b0;
    exp_col   = 4'b1110;
    exp_code  = 4'hF;
    exp_valid = 1'b0;
    exp_press = 1'b0;
  endtask

  // Candidate: -1 none, -2 several keys, else key code. Accept when the last DS agree.
  task automatic model_eval();
    int n;
    int code;
    int cand;
    bit all_same;
    n = 0;
    code = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (snap[r][c]) begin
          n++;
          code = kmap[r][c];
        end
    cand = (n == 0) ? -1 : ((n == 1) ? code : -2);
    hist.push_back(cand);
    if (hist.size() > DS) void'(hist.pop_front());
    if (hist.size() == DS && cand != -2 && cand != stable_m) begin
      all_same = 1'b1;
      foreach (hist[i]) if (hist[i] != cand) all_same = 1'b0;
      if (all_same) begin
        stable_m  = cand;
        exp_press = (cand >= 0);
      end
    end
    exp_valid = (stable_m >= 0);
    exp_code  = (stable_m >= 0) ? 4'(stable_m) : 4'hF;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        model_reset();
      end else begin
        e_m++;
        q_m = e_m % SWEEP;
        exp_press = 1'b0;
        if (q_m != 0 && q_m % SD == 0)
          for (int r = 0; r < 4; r++) snap[r][q_m / SD - 1] = held[r][q_m / SD - 1];
        if (q_m == 0) model_eval();
        exp_col = 4'b1111 ^ (4'b0001 << ((q_m == 4 * SD) ? 3 : q_m / SD));
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      chk("col", col, exp_col);
      chk("key_code", key_code, exp_code);
      chk("key_valid", key_valid, exp_valid);
      chk("key_press", key_press, exp_press);
      if (key_press === 1'b1) press_cnt++;
    end
  end

  task automatic align();
    for (int i = 0; i <= SWEEP && q_m != 0; i++) @(negedge clock);
    if (q_m != 0) begin
      checks++;
      errors++;
      $display("FAIL align: sweep start not reached, phase %0d", q_m);
    end
  endtask

  task automatic wait_valid(input logic want, input int budget, input string name);
    for (int i = 0; i < budget && key_valid !== want; i++) @(negedge clock);
    checks++;
    if (key_valid !== want) begin
      errors++;
      $display("FAIL %s: key_valid %b after %0d cycles, expected %b", name, key_valid, budget, want);
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) held[r][c] = 1'b0;
  endtask

  initial begin
    int p0;
    int lowcnt;
    clear_keys();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_col", col, 4'b1110);
    chk("rst_code", key_code, 4'hF);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_press", key_press, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Idle sweeps.
    repeat (5 * SWEEP) @(negedge clock);
    chk("idle_press", press_cnt, 0);
    chk("idle_valid", key_valid, 1'b0);
    chk("idle_code", key_code, 4'hF);

    // Key 6 (row1, col2): acquire, hold, release.
    align();
    p0 = press_cnt;
    held[1][2] = 1'b1;
    wait_valid(1'b1, 3 * SWEEP + 3, "acq6");
    repeat (2) @(negedge clock);
    chk("code6", key_code, 4'h6);
    chk("press6", press_cnt - p0, 1);
    repeat (10 * SWEEP) @(negedge clock);
    chk("hold6_press", press_cnt - p0, 1);
    align();
    held[1][2] = 1'b0;
    repeat (2 * SWEEP + 2) @(negedge clock);
    chk("rel6_valid", key_valid, 1'b0);
    chk("rel6_code", key_code, 4'hF);
    chk("rel6_press", press_cnt - p0, 1);

    // Key F (row3, col1).
    align();
    p0 = press_cnt;
    held[3][1] = 1'b1;
    wait_valid(1'b1, 3 * SWEEP + 3, "acqF");
    repeat (2) @(negedge clock);
    chk("codeF", key_code, 4'hF);
    chk("pressF", press_cnt - p0, 1);
    align();
    clear_keys();
    repeat (3 * SWEEP) @(negedge clock);

    // Two keys at once from idle.
    align();
    p0 = press_cnt;
    held[0][0] = 1'b1;
    held[2][3] = 1'b1;
    repeat (4 * SWEEP) @(negedge clock);
    chk("multi_valid", key_valid, 1'b0);
    chk("multi_code", key_code, 4'hF);
    chk("multi_press", press_cnt - p0, 0);
    align();
    clear_keys();
    repeat (3 * SWEEP) @(negedge clock);

    // Roll 5 -> 9 without release.
    align();
    p0 = press_cnt;
    held[1][1] = 1'b1;
    wait_valid(1'b1, 3 * SWEEP + 3, "acq5");
    repeat (2) @(negedge clock);
    chk("code5", key_code, 4'h5);
    align();
    held[1][1] = 1'b0;
    held[2][2] = 1'b1;
    lowcnt = 0;
    for (int i = 0; i < 3 * SWEEP; i++) begin
      @(negedge clock);
      if (key_valid !== 1'b1) lowcnt++;
    end
    chk("roll_valid_drop", lowcnt, 0);
    chk("code9", key_code, 4'h9);
    chk("roll_press", press_cnt - p0, 2);
    align();
    clear_keys();
    repeat (3 * SWEEP) @(negedge clock);

    // Key 8, then reset mid-slot while it stays held.
    align();
    held[2][1] = 1'b1;
    wait_valid(1'b1, 3 * SWEEP + 3, "acq8");
    repeat (2) @(negedge clock);
    chk("code8", key_code, 4'h8);
    align();
    repeat (6) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_col", col, 4'b1110);
    chk("midrst_code", key_code, 4'hF);
    chk("midrst_valid", key_valid, 1'b0);
    @(negedge clock);
    p0 = press_cnt;
    reset_n = 1'b1;
    wait_valid(1'b1, 3 * SWEEP + 3, "reacq8");
    repeat (2) @(negedge clock);
    chk("recode8", key_code, 4'h8);
    chk("repress8", press_cnt - p0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
